// File: rtl/dram_test_master_if.sv
// CPU-side local bus between the memory test master and the DRAM controller.
interface dram_test_master_if;
   logic [29:0] busAddr;
   logic [1:0]  busSIZ;
   logic        busRWn;
   logic        busASn;
   logic        ramCEn;
   logic        busCBREQn;
   logic        cpuCBACKn;
   logic        ramACKn;
   logic [31:0] busDataOut;
   logic        busDataOE;
   logic [31:0] busDataIn;

   modport master (
      output busAddr, busSIZ, busRWn, busASn, ramCEn,
      output busCBREQn, busDataOut, busDataOE,
      input  cpuCBACKn, ramACKn, busDataIn
   );

   modport slave (
      input  busAddr, busSIZ, busRWn, busASn, ramCEn,
      input  busCBREQn, busDataOut, busDataOE,
      output cpuCBACKn, ramACKn, busDataIn
   );
endinterface

// File: rtl/dram_test_master.sv
// Power-on DRAM test master: pattern write pass then read/compare pass.
// Optional cache-burst reads: define DRAM_TEST_BURST_EN.
module dram_test_master #(
   parameter int TIMEOUT = 255
) (
   input  logic               sysClk,
   input  logic               sysRESETn,
   input  logic               start,
   input  logic [29:0]        startAddr,
   input  logic [15:0]        wordCount,
   input  logic [31:0]        seed,
   dram_test_master_if.master bus,
   output logic               busy,
   output logic               done,
   output logic [1:0]         errCode,
   output logic [29:0]        failAddr,
   output logic [31:0]        failData
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, WSTRB, WWAIT, WGAP, RSTRB, RWAIT, RGAP, DONE
   } state_t;

   state_t        state, state_d;
   logic [29:0]   addr_q, addr_d, base_q, base_d;
   logic [15:0]   rem_q, rem_d, cnt_q, cnt_d;
   logic [31:0]   seed_q, seed_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [1:0]    beat_q, beat_d;
   logic          burst_q, burst_d;
   logic          as_q, as_d, rw_q, rw_d;
   logic          cbreq_q, cbreq_d, oe_q, oe_d;
   logic [31:0]   dout_q, dout_d;
   logic          busy_d, done_d;
   logic [1:0]    err_d;
   logic [29:0]   faddr_d;
   logic [31:0]   fdata_d;
   logic          fin;
   logic [1:0]    fin_err;
   logic [31:0]   pat;
   logic [29:0]   addr_inc;
   logic          tmo, burst_ok, cback_hi;
   logic          unused_bits;

`ifdef DRAM_TEST_BURST_EN
   assign burst_ok = (addr_q[3:2] == 2'b00) && (rem_q >= 16'd4);
   assign cback_hi = bus.cpuCBACKn;
   assign unused_bits = ^startAddr[1:0];
`else
   assign burst_ok = 1'b0;
   assign cback_hi = 1'b0;
   assign unused_bits = ^{startAddr[1:0], bus.cpuCBACKn};
`endif

   assign pat      = {2'b00, addr_q[29:2], 2'b00} ^ seed_q;
   assign addr_inc = addr_q + 30'd4;
   assign tmo      = (tmr_q == TW'(TIMEOUT - 1));

   assign bus.busAddr    = addr_q;
   assign bus.busSIZ     = 2'b00;
   assign bus.busRWn     = rw_q;
   assign bus.busASn     = as_q;
   assign bus.ramCEn     = as_q;
   assign bus.busCBREQn  = cbreq_q;
   assign bus.busDataOut = dout_q;
   assign bus.busDataOE  = oe_q;

   always_comb begin
      state_d = state;
      addr_d  = addr_q;
      base_d  = base_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      seed_d  = seed_q;
      tmr_d   = tmr_q;
      beat_d  = beat_q;
      burst_d = burst_q;
      as_d    = as_q;
      rw_d    = rw_q;
      cbreq_d = cbreq_q;
      oe_d    = oe_q;
      dout_d  = dout_q;
      busy_d  = busy;
      done_d  = done;
      err_d   = errCode;
      faddr_d = failAddr;
      fdata_d = failData;
      fin     = 1'b0;
      fin_err = 2'b00;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               busy_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = 2'b00;
               faddr_d = '0;
               fdata_d = '0;
               addr_d  = {startAddr[29:2], 2'b00};
               base_d  = {startAddr[29:2], 2'b00};
               rem_d   = wordCount;
               cnt_d   = wordCount;
               seed_d  = seed;
               if (wordCount == 16'd0) begin
                  fin = 1'b1;
               end else if (startAddr[29:28] == 2'b11) begin
                  fin     = 1'b1;
                  fin_err = 2'b11;
               end else begin
                  state_d = WSTRB;
               end
            end
         end
         WSTRB: begin
            if (addr_q[29:28] == 2'b11) begin
               fin     = 1'b1;
               fin_err = 2'b11;
            end else begin
               rw_d    = 1'b0;
               as_d    = 1'b0;
               oe_d    = 1'b1;
               dout_d  = pat;
               tmr_d   = '0;
               state_d = WWAIT;
            end
         end
         WWAIT: begin
            if (!bus.ramACKn) begin
               as_d    = 1'b1;
               oe_d    = 1'b0;
               state_d = WGAP;
            end else if (tmo) begin
               fin     = 1'b1;
               fin_err = 2'b10;
               faddr_d = addr_q;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         WGAP: begin
            if (rem_q == 16'd1) begin
               addr_d  = base_q;
               rem_d   = cnt_q;
               state_d = RSTRB;
            end else begin
               addr_d  = addr_inc;
               rem_d   = rem_q - 16'd1;
               state_d = WSTRB;
            end
         end
         RSTRB: begin
            if (addr_q[29:28] == 2'b11) begin
               fin     = 1'b1;
               fin_err = 2'b11;
            end else begin
               rw_d    = 1'b1;
               as_d    = 1'b0;
               cbreq_d = !burst_ok;
               burst_d = burst_ok;
               beat_d  = 2'd0;
               tmr_d   = '0;
               state_d = RWAIT;
            end
         end
         RWAIT: begin
            if (!bus.ramACKn) begin
               if (bus.busDataIn != pat) begin
                  fin     = 1'b1;
                  fin_err = 2'b01;
                  faddr_d = addr_q;
                  fdata_d = bus.busDataIn;
               end else begin
                  addr_d = addr_inc;
                  rem_d  = rem_q - 16'd1;
                  tmr_d  = '0;
                  beat_d = beat_q + 2'd1;
                  // refused burst or last beat closes the cycle
                  if (!burst_q || beat_q == 2'd3 ||
                      (beat_q == 2'd0 && cback_hi)) begin
                     as_d    = 1'b1;
                     cbreq_d = 1'b1;
                     state_d = RGAP;
                  end else if (beat_q == 2'd2) begin
                     cbreq_d = 1'b1;
                  end
               end
            end else if (tmo) begin
               fin     = 1'b1;
               fin_err = 2'b10;
               faddr_d = addr_q;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         RGAP: begin
            if (rem_q == 16'd0) fin = 1'b1;
            else state_d = RSTRB;
         end
      endcase
      if (fin) begin
         state_d = DONE;
         done_d  = 1'b1;
         busy_d  = 1'b0;
         err_d   = fin_err;
         as_d    = 1'b1;
         rw_d    = 1'b1;
         oe_d    = 1'b0;
         cbreq_d = 1'b1;
      end
   end

   always_ff @(posedge sysClk or negedge sysRESETn) begin
      if (!sysRESETn) begin
         state    <= IDLE;
         addr_q   <= '0;
         base_q   <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         seed_q   <= '0;
         tmr_q    <= '0;
         beat_q   <= '0;
         burst_q  <= 1'b0;
         as_q     <= 1'b1;
         rw_q     <= 1'b1;
         cbreq_q  <= 1'b1;
         oe_q     <= 1'b0;
         dout_q   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         errCode  <= 2'b00;
         failAddr <= '0;
         failData <= '0;
      end else begin
         state    <= state_d;
         addr_q   <= addr_d;
         base_q   <= base_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         seed_q   <= seed_d;
         tmr_q    <= tmr_d;
         beat_q   <= beat_d;
         burst_q  <= burst_d;
         as_q     <= as_d;
         rw_q     <= rw_d;
         cbreq_q  <= cbreq_d;
         oe_q     <= oe_d;
         dout_q   <= dout_d;
         busy     <= busy_d;
         done     <= done_d;
         errCode  <= err_d;
         failAddr <= faddr_d;
         failData <= fdata_d;
      end
   end
endmodule

// File: tb/tb_dram_test_master.sv
// Bench for dram_test_master: table of test runs against a RAM model,
// with a queue of expected bus cycles checked as the DUT issues them.
module tb_dram_test_master;
   localparam int TMO = 255;
`ifdef DRAM_TEST_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic        sysClk = 1'b0;
   logic        sysRESETn = 1'b0;
   logic        start = 1'b0;
   logic [29:0] startAddr = '0;
   logic [15:0] wordCount = '0;
   logic [31:0] seed = '0;
   logic        busy, done;
   logic [1:0]  errCode;
   logic [29:0] failAddr;
   logic [31:0] failData;

   dram_test_master_if bus ();

   dram_test_master #(.TIMEOUT(TMO)) dut (
      .sysClk    (sysClk),
      .sysRESETn (sysRESETn),
      .start     (start),
      .startAddr (startAddr),
      .wordCount (wordCount),
      .seed      (seed),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .errCode   (errCode),
      .failAddr  (failAddr),
      .failData  (failData)
   );

   always #5 sysClk = ~sysClk;

   typedef struct packed {
      logic        rw;
      logic [29:0] a;
      logic [31:0] d;
   } bus_t;

   typedef struct {
      logic [29:0] sa;
      logic [15:0] wc;
      logic [31:0] sd;
      bit          ack;
      bit          cback;
      bit          corr;
      logic [29:0] ca;
      logic [1:0]  err;
      bit          chkf;
      logic [29:0] fa;
      logic [31:0] fd;
      int          cyc_nb;
      int          cyc_b;
      int          cbq_b;
   } vec_t;

   int   n_chk = 0;
   int   n_fail = 0;
   bus_t exp_q[$];
   logic [31:0] mem [logic [29:0]];
   bit   ack_en = 1'b1;
   bit   cback_en = 1'b1;
   bit   corr_en = 1'b0;
   logic [29:0] corr_addr = '0;
   int   cyc_cnt = 0;
   int   cbq_cnt = 0;
   int   as_low_cnt = 0;
   logic as_prev = 1'b1;
   vec_t tv[10];

   function automatic logic [31:0] pat(logic [29:0] a, logic [31:0] s);
      return {2'b00, a[29:2], 2'b00} ^ s;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic sb_check();
      bus_t e;
      n_chk++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL sb_extra: unexpected cycle at %0h", bus.busAddr);
         return;
      end
      e = exp_q.pop_front();
      chk("sb_rw", bus.busRWn, e.rw);
      chk("sb_addr", bus.busAddr, e.a);
      chk("sb_oe", bus.busDataOE, !e.rw);
      chk("sb_siz", bus.busSIZ, 2'b00);
      chk("sb_ce", bus.ramCEn, 1'b0);
      if (!e.rw) chk("sb_wdata", bus.busDataOut, e.d);
   endtask

   // RAM model: acknowledges every strobed clock, presents data at negedge
   always @(negedge sysClk) begin
      bus.ramACKn = 1'b1;
      bus.cpuCBACKn = 1'b1;
      if (!bus.busASn) begin
         as_low_cnt++;
         if (as_prev) cyc_cnt++;
         if (!bus.busCBREQn) cbq_cnt++;
         if (cback_en) bus.cpuCBACKn = bus.busCBREQn;
         if (ack_en) begin
            bus.ramACKn = 1'b0;
            sb_check();
            if (!bus.busRWn) begin
               mem[bus.busAddr] = bus.busDataOut;
            end else begin
               bus.busDataIn = mem[bus.busAddr];
               if (corr_en && bus.busAddr == corr_addr)
                  bus.busDataIn[0] = ~bus.busDataIn[0];
            end
         end
      end
      as_prev = bus.busASn;
   end

   task automatic arm(input vec_t v);
      logic [29:0] a0;
      exp_q.delete();
      ack_en = v.ack;
      cback_en = v.cback;
      corr_en = v.corr;
      corr_addr = v.ca;
      cyc_cnt = 0;
      cbq_cnt = 0;
      as_low_cnt = 0;
      a0 = {v.sa[29:2], 2'b00};
      for (int k = 0; k < int'(v.wc); k++)
         exp_q.push_back({1'b0, a0 + 30'(4 * k), pat(a0 + 30'(4 * k), v.sd)});
      for (int k = 0; k < int'(v.wc); k++)
         exp_q.push_back({1'b1, a0 + 30'(4 * k), 32'h0});
      startAddr = v.sa;
      wordCount = v.wc;
      seed = v.sd;
   endtask

   task automatic wait_done(input string nm);
      int t = 0;
      while (!done && t < 2000) begin
         @(posedge sysClk); #1;
         t++;
      end
      n_chk++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s_done: got 0 after 2000 clocks, expected 1", nm);
      end
   endtask

   task automatic run_test(input vec_t v, input string nm);
      arm(v);
      start = 1'b1;
      @(posedge sysClk); #1;
      start = 1'b0;
      wait_done(nm);
   endtask

   initial begin
      tv[0] = '{30'h1000, 16'd8, 32'hA5A5A5A5, 1, 1, 0, 30'h0,
                2'd0, 1, 30'h0, 32'h0, 16, 10, 6};
      tv[1] = '{30'h1000, 16'd8, 32'hA5A5A5A5, 1, 0, 0, 30'h0,
                2'd0, 1, 30'h0, 32'h0, 16, 16, 2};
      tv[2] = '{30'h1000, 16'd8, 32'hA5A5A5A5, 1, 1, 1, 30'h1008,
                2'd1, 1, 30'h1008, 32'hA5A5B5AC, 11, 9, 3};
      tv[3] = '{30'h30000000, 16'd4, 32'h1, 1, 1, 0, 30'h0,
                2'd3, 0, 30'h0, 32'h0, 0, 0, 0};
      tv[4] = '{30'h1000, 16'd0, 32'h1, 1, 1, 0, 30'h0,
                2'd0, 1, 30'h0, 32'h0, 0, 0, 0};
      tv[5] = '{30'h2000, 16'd5, 32'h0F0F1234, 1, 1, 0, 30'h0,
                2'd0, 1, 30'h0, 32'h0, 10, 7, 3};
      tv[6] = '{30'h1007, 16'd3, 32'h12345678, 1, 1, 0, 30'h0,
                2'd0, 1, 30'h0, 32'h0, 6, 6, 0};
      tv[7] = '{30'h2FFFFFF8, 16'd4, 32'h0, 1, 1, 0, 30'h0,
                2'd3, 0, 30'h0, 32'h0, 2, 2, 0};
      tv[8] = '{30'h2000, 16'd5, 32'h0F0F1234, 1, 1, 1, 30'h2010,
                2'd1, 1, 30'h2010, 32'h0F0F3225, 10, 7, 3};
      tv[9] = '{30'h1000, 16'd8, 32'hA5A5A5A5, 0, 1, 0, 30'h0,
                2'd2, 1, 30'h1000, 32'h0, 1, 1, 0};

      repeat (3) @(posedge sysClk);
      #1;
      chk("rst_as", bus.busASn, 1'b1);
      chk("rst_ce", bus.ramCEn, 1'b1);
      chk("rst_rw", bus.busRWn, 1'b1);
      chk("rst_cbreq", bus.busCBREQn, 1'b1);
      chk("rst_oe", bus.busDataOE, 1'b0);
      chk("rst_addr", bus.busAddr, 30'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", errCode, 2'b00);
      sysRESETn = 1'b1;
      @(posedge sysClk); #1;

      // start at edge N: idle at N, strobe low after N+1
      arm(tv[0]);
      start = 1'b1;
      @(posedge sysClk); #1;
      start = 1'b0;
      chk("t_n_as", bus.busASn, 1'b1);
      chk("t_n_busy", busy, 1'b1);
      @(posedge sysClk); #1;
      chk("t_n1_as", bus.busASn, 1'b0);
      chk("t_n1_rw", bus.busRWn, 1'b0);
      chk("t_n1_addr", bus.busAddr, 30'h1000);
      wait_done("t_first");
      chk("t_first_err", errCode, 2'b00);

      for (int i = 0; i < 10; i++) begin
         run_test(tv[i], $sformatf("v%0d", i));
         chk($sformatf("v%0d_err", i), errCode, tv[i].err);
         if (tv[i].chkf) begin
            chk($sformatf("v%0d_faddr", i), failAddr, tv[i].fa);
            chk($sformatf("v%0d_fdata", i), failData, tv[i].fd);
         end
         chk($sformatf("v%0d_cycles", i), cyc_cnt,
             BURST ? tv[i].cyc_b : tv[i].cyc_nb);
         chk($sformatf("v%0d_cbreq", i), cbq_cnt,
             BURST ? tv[i].cbq_b : 0);
         chk($sformatf("v%0d_busy", i), busy, 1'b0);
         chk($sformatf("v%0d_as", i), bus.busASn, 1'b1);
         chk($sformatf("v%0d_oe", i), bus.busDataOE, 1'b0);
         if (i == 0) chk("wr_1004", mem[30'h1004], 32'hA5A5B5A1);
      end
      chk("tmo_len", as_low_cnt, TMO);

      // asynchronous reset while waiting for a write acknowledge
      arm(tv[9]);
      start = 1'b1;
      @(posedge sysClk); #1;
      start = 1'b0;
      repeat (20) @(posedge sysClk);
      #1;
      chk("mid_as_pre", bus.busASn, 1'b0);
      #3;
      sysRESETn = 1'b0;
      #1;
      chk("mid_as", bus.busASn, 1'b1);
      chk("mid_ce", bus.ramCEn, 1'b1);
      chk("mid_rw", bus.busRWn, 1'b1);
      chk("mid_oe", bus.busDataOE, 1'b0);
      chk("mid_addr", bus.busAddr, 30'h0);
      chk("mid_dout", bus.busDataOut, 32'h0);
      chk("mid_busy", busy, 1'b0);
      chk("mid_done", done, 1'b0);
      @(posedge sysClk); #1;
      sysRESETn = 1'b1;
      @(posedge sysClk); #1;
      run_test(tv[0], "post_rst");
      chk("post_rst_err", errCode, 2'b00);
      chk("post_rst_cycles", cyc_cnt, BURST ? 10 : 16);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dram_test_master.md
# dram_test_master

Bus-cycle initiator that drives the CPU-side port of the DRAM controller for power-on memory test and DMA-style bring-up. It issues 68030-style longword write cycles with a deterministic pattern across a programmed range, then reads the range back (optionally with cache-burst requests) and compares. It sits on the local bus in place of the CPU while the CPU is held off, and reports pass/fail plus the first failing address and data.

## Interface
- `TIMEOUT`, default 255: clocks to wait for `ramACKn` before aborting a transfer.
- `sysClk` in 1: system clock; all logic on rising edge.
- `sysRESETn` in 1: reset, asynchronous, active-low.
- `start` in 1: one-clock pulse; begins a test when idle.
- `startAddr` in 30: byte address of the first longword; bits [1:0] ignored and forced to 0.
- `wordCount` in 16: number of longwords to test; 0 completes immediately with pass.
- `seed` in 32: pattern seed.
- `busAddr` out 30: bus address; reset 0.
- `busSIZ` out 2: transfer size, always 2'b00 (longword); reset 2'b00.
- `busRWn` out 1: 1 = read, 0 = write; reset 1.
- `busASn` out 1: address strobe; reset 1.
- `ramCEn` out 1: RAM chip enable; follows `busASn`; reset 1.
- `busCBREQn` out 1: cache burst request; reset 1.
- `cpuCBACKn` in 1: burst acknowledge from controller.
- `ramACKn` in 1: cycle acknowledge from controller.
- `busDataOut` out 32: write data; reset 0. `busDataOE` out 1: drive enable, high only during write cycles; reset 0.
- `busDataIn` in 32: read data, valid when `ramACKn` sampled low.
- `busy` out 1, `done` out 1, `errCode` out 2, `failAddr` out 30, `failData` out 32: status; all reset 0.

## Operation
- Pattern: data(addr) = {addr[29:2], 2'b00} ^ seed.
- States: IDLE, WSTRB, WWAIT, WGAP, RSTRB, RWAIT, RGAP, DONE.
- IDLE: on `start`, clear status, latch inputs, `busy`=1. If `wordCount`==0 -> DONE pass. If `startAddr`[29:28]==2'b11 (controller config space) -> DONE with `errCode`=2'b11.
- WSTRB: drive address, `busRWn`=0, data, `busDataOE`=1, assert `busASn`/`ramCEn` -> WWAIT.
- WWAIT: on `ramACKn` low -> WGAP. Timer expiry -> DONE, `errCode`=2'b10, `failAddr`=current address.
- WGAP: negate strobes and `busDataOE` for one clock; advance address by 4, decrement remaining; if remaining 0, reload start address/count -> RSTRB, else -> WSTRB.
- RSTRB: `busRWn`=1, assert strobes; assert `busCBREQn` iff burst feature enabled, address[3:2]==0 and remaining >= 4 -> RWAIT.
- RWAIT: each clock with `ramACKn` low is one longword: compare `busDataIn` to pattern, advance address/count. Mismatch -> DONE, `errCode`=2'b01, `failAddr`/`failData` = address/received data of the first mismatch. Within a burst, negate `busCBREQn` on the clock the third longword is accepted; burst ends after the fourth. If `cpuCBACKn` is high when the first longword is accepted, negate `busCBREQn` and end the cycle after that longword. Non-burst cycle ends after one longword -> RGAP. Timeout as in WWAIT.
- RGAP: strobes negated one clock; remaining 0 -> DONE pass, else -> RSTRB.
- DONE: `done`=1, `busy`=0, strobes negated, hold until next `start`. `start` while busy is ignored.
- Address arithmetic 30-bit, wraps 0x3FFFFFFC -> 0x00000000; a wrap into [29:28]==2'b11 aborts with `errCode`=2'b11 before issuing the cycle.

## Timing
- `start` sampled at rising edge N; first `busASn` low at edge N+1.
- Strobes remain asserted until the acknowledge is sampled; negated the following edge. Minimum one idle clock (WGAP/RGAP) between cycles.
- Timeout counter resets on each strobe assertion and each accepted longword; expiry at exactly `TIMEOUT` clocks without acknowledge.
- Reset mid-test: all outputs return to reset values asynchronously; status cleared; no resume.

## Configuration
- `DRAM_TEST_BURST_EN`: defined -> reads use cache bursts as above. Undefined -> `busCBREQn` tied 1, every read is a single longword cycle; `cpuCBACKn` ignored.

## Test plan
- startAddr 0x00001000, wordCount 8, seed 0xA5A5A5A5, ideal RAM model -> 8 writes then reads, `done`=1, `errCode`=0; write at 0x1004 carries 0xA5A5B5A1.
- Same, burst enabled, model grants `cpuCBACKn` -> two 4-longword bursts, `busCBREQn` negated with third acknowledge of each.
- Model corrupts bit 0 of word at 0x00001008 -> `errCode`=2'b01, `failAddr`=0x00001008, `failData`=expected ^ 1.
- Model never acknowledges -> `errCode`=2'b10 after 255 clocks, `failAddr`=0x00001000, strobes negated.
- startAddr 0x30000000 -> immediate `done`, `errCode`=2'b11, no `busASn` assertion; wordCount 0 -> `done` pass, no cycles.
- Assert `sysRESETn` low during WWAIT -> all outputs at reset values same clock; subsequent `start` runs a clean test.
